// File: rtl/fwd_track_unit.sv
// Operand-forwarding unit: tracks in-flight producers and resolves NUM_SRC ID operands.
// Optional statistics counters are enabled with the FWD_STATS_EN macro.
module fwd_src_resolve #(
    parameter int DATA_W           = 32,
    parameter int REG_AW           = 5,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    parameter int SEL_W            = 2
) (
    input  logic [REG_AW-1:0]                 rs,
    input  logic [DATA_W-1:0]                 rf_data,
    input  logic [FWD_DEPTH-1:0][DATA_W-1:0]  stage_data,
    input  logic [FWD_DEPTH-1:0]              rec_v,
    input  logic [FWD_DEPTH-1:0]              rec_we,
    input  logic [FWD_DEPTH-1:0]              rec_ld,
    input  logic [FWD_DEPTH-1:0][REG_AW-1:0]  rec_rd,
    output logic [DATA_W-1:0]                 operand,
    output logic [SEL_W-1:0]                  sel,
    output logic                              hazard
);
    // Scan oldest to youngest so the youngest match overwrites the rest.
    always_comb begin
        operand = rf_data;
        sel     = '0;
        hazard  = 1'b0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (rec_v[k] && rec_we[k] && (rec_rd[k] == rs) && (rs != '0)) begin
                operand = stage_data[k];
                sel     = SEL_W'(k + 1);
                hazard  = rec_ld[k] && (k < LOAD_READY_STAGE);
            end
        end
    end
endmodule

module fwd_track_unit #(
    parameter int DATA_W           = 32,
    parameter int REG_AW           = 5,
    parameter int NUM_SRC          = 2,
    parameter int FWD_DEPTH        = 3,
    parameter int LOAD_READY_STAGE = 1,
    localparam int SEL_W           = $clog2(FWD_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_we,
    input  logic                          id_is_load,
    input  logic [NUM_SRC*REG_AW-1:0]     id_rs_flat,
    input  logic [NUM_SRC*DATA_W-1:0]     rf_data_flat,
    input  logic [FWD_DEPTH*DATA_W-1:0]   stage_data_flat,
    input  logic                          flush,
    output logic [NUM_SRC*DATA_W-1:0]     operand_flat,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel_flat,
    output logic                          stall
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [31:0]                   fwd_cnt
`endif
);
    logic [FWD_DEPTH-1:0]              vld_pipe;
    logic [FWD_DEPTH-1:0]              we_pipe;
    logic [FWD_DEPTH-1:0]              ld_pipe;
    logic [FWD_DEPTH-1:0][REG_AW-1:0]  rd_pipe;
    logic [FWD_DEPTH-1:0][DATA_W-1:0]  stage_data;
    logic [NUM_SRC-1:0]                hazard;
    logic [NUM_SRC-1:0]                fwd_hit;

    assign stage_data = stage_data_flat;

    genvar i;
    generate
        for (i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_resolve #(
                .DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_DEPTH(FWD_DEPTH),
                .LOAD_READY_STAGE(LOAD_READY_STAGE), .SEL_W(SEL_W)
            ) u_res (
                .rs        (id_rs_flat[i*REG_AW +: REG_AW]),
                .rf_data   (rf_data_flat[i*DATA_W +: DATA_W]),
                .stage_data(stage_data),
                .rec_v     (vld_pipe),
                .rec_we    (we_pipe),
                .rec_ld    (ld_pipe),
                .rec_rd    (rd_pipe),
                .operand   (operand_flat[i*DATA_W +: DATA_W]),
                .sel       (fwd_sel_flat[i*SEL_W +: SEL_W]),
                .hazard    (hazard[i])
            );
            assign fwd_hit[i] = |fwd_sel_flat[i*SEL_W +: SEL_W];
        end
    endgenerate

    // Flush wins over a load-use hazard: the squashed instruction never needs its operands.
    assign stall = id_valid && (|hazard) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            we_pipe  <= '0;
            ld_pipe  <= '0;
            rd_pipe  <= '0;
        end else begin
            for (int k = FWD_DEPTH - 1; k >= 1; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                we_pipe[k]  <= we_pipe[k-1];
                ld_pipe[k]  <= ld_pipe[k-1];
                rd_pipe[k]  <= rd_pipe[k-1];
            end
            vld_pipe[0] <= id_valid && !stall && !flush;
            we_pipe[0]  <= id_we;
            ld_pipe[0]  <= id_is_load;
            rd_pipe[0]  <= id_rd;
        end
    end

`ifdef FWD_STATS_EN
    localparam int CNT_W = $clog2(NUM_SRC + 1);
    logic [CNT_W-1:0] n_fwd;
    logic [32:0]      fwd_sum;

    always_comb begin
        n_fwd = '0;
        for (int s = 0; s < NUM_SRC; s++) n_fwd = n_fwd + CNT_W'(fwd_hit[s]);
    end

    assign fwd_sum = {1'b0, fwd_cnt} + 33'(n_fwd);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
            if (id_valid && !stall && !flush)
                fwd_cnt <= fwd_sum[32] ? '1 : fwd_sum[31:0];
        end
    end
`else
    logic unused_fwd_hit;
    assign unused_fwd_hit = ^fwd_hit;
`endif
endmodule
